// File: rtl/uart_line_pkg.sv
// rtl/uart_line_pkg.sv - shared constants and state types for the UART line adapter
package uart_line_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP,
    R_BREAK
  } rx_state_t;

  typedef enum logic [1:0] {
    T_IDLE,
    T_START,
    T_DATA,
    T_STOP
  } tx_state_t;

endpackage

// File: rtl/uart_line_fifo.sv
// rtl/uart_line_fifo.sv - synchronous FIFO; push while full is accepted only alongside a pop
module uart_line_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_line_fifo: DEPTH must be a power of 2 and >= 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  // Pointer compare with a wrap bit distinguishes full from empty; head reads as zero when empty.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    pop_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // Storage and pointer registers; reset empties the FIFO.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/uart_line_adapter.sv
// rtl/uart_line_adapter.sv - 8N1 bit-level bridge between UART pins and a byte stream model
module uart_line_adapter
  import uart_line_pkg::*;
#(
  parameter int DIV      = 16,
  parameter int RX_DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uart_txd,
  output logic       uart_rxd,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_bits,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_bits,
  input  logic       err_clear,
  output logic       framing_err,
  output logic       overrun
);

  localparam int             CW       = $clog2(DIV);
  localparam logic [CW-1:0]  CNT_FULL = CW'(DIV - 1);
  localparam logic [CW-1:0]  CNT_HALF = CW'(DIV / 2 - 1);
  localparam logic [2:0]     LAST_BIT = 3'(DATA_BITS - 1);

  if (DIV < 4 || (DIV % 2) != 0) begin : g_bad_div
    $error("uart_line_adapter: DIV must be even and >= 4");
  end

  // ---------------- RX path ----------------
  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  rx_state_t            rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [2:0]           rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_push;
  logic                 rx_stop_err;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;
  logic                 framing_q, framing_d;
  logic                 overrun_q, overrun_d;

  // Two-flop synchronizer for the asynchronous DUT transmit line.
  always_comb begin
    sync1_d = uart_txd;
    sync2_d = sync1_q;
  end

  // Synchronizer registers idle high so reset never looks like a start bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  // RX next-state: half-bit delay to centre on the start bit, then one sample per bit period.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_idx_d    = rx_idx_q;
    rx_shift_d  = rx_shift_q;
    rx_push     = 1'b0;
    rx_stop_err = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        if (!sync2_q) begin
          rx_cnt_d   = CNT_HALF;
          rx_state_d = R_START;
        end
      end
      R_START: begin
        if (rx_cnt_q == '0) begin
          if (!sync2_q) begin
            rx_cnt_d   = CNT_FULL;
            rx_idx_d   = '0;
            rx_state_d = R_DATA;
          end else begin
            rx_state_d = R_IDLE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CW'(1);
        end
      end
      R_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_shift_d[rx_idx_q] = sync2_q;
          rx_cnt_d             = CNT_FULL;
          if (rx_idx_q == LAST_BIT) begin
            rx_state_d = R_STOP;
          end else begin
            rx_idx_d = rx_idx_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CW'(1);
        end
      end
      R_STOP: begin
        if (rx_cnt_q == '0) begin
          if (sync2_q) begin
            rx_push    = 1'b1;
            rx_state_d = R_IDLE;
          end else begin
            rx_stop_err = 1'b1;
            rx_state_d  = R_BREAK;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CW'(1);
        end
      end
      R_BREAK: begin
        if (sync2_q) rx_state_d = R_IDLE;
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  // RX state registers; reset discards any partially received byte.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state_q <= R_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  uart_line_fifo #(
    .DEPTH (RX_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_rx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (rx_push),
    .push_data (rx_shift_q),
    .pop       (fifo_pop),
    .pop_data  (out_bits),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Stream handshake and sticky flags; a set event in the same cycle as err_clear wins.
  always_comb begin
    out_valid = !fifo_empty;
    fifo_pop  = out_valid && out_ready;
    framing_d = (framing_q && !err_clear) || rx_stop_err;
    overrun_d = (overrun_q && !err_clear) || (rx_push && fifo_full && !fifo_pop);
  end

  // Sticky flag registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      framing_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      framing_q <= framing_d;
      overrun_q <= overrun_d;
    end
  end

  assign framing_err = framing_q;
  assign overrun     = overrun_q;

  // ---------------- TX path ----------------
  tx_state_t            tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [2:0]           tx_idx_q, tx_idx_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 rxd_q, rxd_d;

  // TX next-state: each line level is registered and held for a full bit period.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    rxd_d      = rxd_q;
    in_ready   = (tx_state_q == T_IDLE) && !reset;
    case (tx_state_q)
      T_IDLE: begin
        rxd_d = 1'b1;
        if (in_valid) begin
          tx_shift_d = in_bits;
          rxd_d      = 1'b0;
          tx_cnt_d   = CNT_FULL;
          tx_state_d = T_START;
        end
      end
      T_START: begin
        if (tx_cnt_q == '0) begin
          rxd_d      = tx_shift_q[0];
          tx_shift_d = tx_shift_q >> 1;
          tx_idx_d   = '0;
          tx_cnt_d   = CNT_FULL;
          tx_state_d = T_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q - CW'(1);
        end
      end
      T_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = CNT_FULL;
          if (tx_idx_q == LAST_BIT) begin
            rxd_d      = 1'b1;
            tx_state_d = T_STOP;
          end else begin
            rxd_d      = tx_shift_q[0];
            tx_shift_d = tx_shift_q >> 1;
            tx_idx_d   = tx_idx_q + 3'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - CW'(1);
        end
      end
      T_STOP: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = T_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q - CW'(1);
        end
      end
      default: tx_state_d = T_IDLE;
    endcase
  end

  // TX registers; reset aborts a frame and drives the line idle high immediately.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state_q <= T_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      rxd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      rxd_q      <= rxd_d;
    end
  end

  assign uart_rxd = rxd_q;

endmodule
